// File: rtl/morse_key_capture.sv
// Morse key capture: samples a debounced key, classifies presses as dot/dash
// and gaps as element/letter/word gaps, encodes symbols as five 2-bit
// elements (MSB first) and packs 16 symbols into a 160-bit frame.
//
// Handshake: a frame is offered with seq_valid=1; sequences and frame_len
// hold stable until the cycle where seq_valid & seq_ready are both 1, which
// is the single transfer point. A closed frame waiting for the output port is
// "pending"; symbols committed while a frame is pending are dropped.
module morse_key_capture #(
  parameter int UNIT_CYCLES  = 16,
  parameter int DASH_UNITS   = 2,
  parameter int LETTER_UNITS = 3,
  parameter int WORD_UNITS   = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_in,
  input  logic         flush,
  input  logic         seq_ready,
  output logic [159:0] sequences,
  output logic         seq_valid,
  output logic [4:0]   frame_len,
  output logic         sym_valid,
  output logic [9:0]   sym_code,
  output logic         sym_drop,
  output logic [1:0]   dbg_state
);

  localparam int DASH_LIM   = DASH_UNITS * UNIT_CYCLES;
  localparam int LETTER_LIM = LETTER_UNITS * UNIT_CYCLES;
  localparam int WORD_LIM   = WORD_UNITS * UNIT_CYCLES;
  localparam int CW         = $clog2(WORD_LIM + 1);

  localparam logic [9:0] SPACE_CODE = 10'h2FF;
  localparam logic [9:0] EMPTY_CODE = 10'h3FF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2,
    S_WGAP  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx, cnt_inc;
  logic            ks_meta, ks;

  logic            append, append_dash, commit_sym, commit_space, commit;
  logic [9:0]      commit_code;

  logic [9:0]      sym_work;
  logic [2:0]      elem_cnt;
  logic            ovf;
  logic            need_space;

  logic [159:0]    work;
  logic [4:0]      idx;
  logic            pend;
  logic            out_free, write, close_frame;

  assign dbg_state = state;

  // Two-flop synchronizer for the asynchronous key level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_meta <= 1'b0;
      ks      <= 1'b0;
    end else begin
      ks_meta <= key_in;
      ks      <= ks_meta;
    end
  end

  // FSM state and timing counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  // Next-state logic: classify press length and gap length.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    append       = 1'b0;
    append_dash  = 1'b0;
    commit_sym   = 1'b0;
    commit_space = 1'b0;
    case (state)
      S_IDLE: begin
        if (ks) begin
          state_nx = S_PRESS;
          cnt_nx   = CW'(1);
        end
      end
      S_PRESS: begin
        if (ks) begin
          cnt_nx = cnt_inc;
        end else begin
          append      = 1'b1;
          append_dash = (int'(cnt) >= DASH_LIM);
          state_nx    = S_GAP;
          cnt_nx      = CW'(1);
        end
      end
      S_GAP: begin
        if (ks) begin
          state_nx = S_PRESS;
          cnt_nx   = CW'(1);
        end else begin
          cnt_nx = cnt_inc;
          if (int'(cnt_inc) == LETTER_LIM) begin
            commit_sym = 1'b1;
            state_nx   = S_WGAP;
          end
        end
      end
      S_WGAP: begin
        if (ks) begin
          state_nx = S_PRESS;
          cnt_nx   = CW'(1);
        end else begin
          cnt_nx = cnt_inc;
          if (int'(cnt_inc) == WORD_LIM) begin
            commit_space = need_space;
            state_nx     = S_IDLE;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Commit selection and frame-control decode.
  always_comb begin
    commit      = commit_sym | commit_space;
    commit_code = commit_space ? SPACE_CODE : (ovf ? EMPTY_CODE : sym_work);
    out_free    = !seq_valid || seq_ready;
    write       = commit && !pend;
    close_frame = !pend && ((write && (idx == 5'd15)) ||
                            (flush && (write || (idx != 5'd0))));
  end

  // Symbol assembly: elements fill from the MSB pair; a sixth sets overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_work <= EMPTY_CODE;
      elem_cnt <= '0;
      ovf      <= 1'b0;
    end else if (commit_sym) begin
      sym_work <= EMPTY_CODE;
      elem_cnt <= '0;
      ovf      <= 1'b0;
    end else if (append) begin
      if (elem_cnt == 3'd5) begin
        ovf <= 1'b1;
      end else begin
        for (int i = 0; i < 5; i++) begin
          if (elem_cnt == 3'(i)) sym_work[9-2*i -: 2] <= {1'b0, append_dash};
        end
        elem_cnt <= elem_cnt + 3'd1;
      end
    end
  end

  // Word-space gating: a space follows only a real symbol in this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      need_space <= 1'b0;
    end else if (close_frame || commit_space) begin
      need_space <= 1'b0;
    end else if (write && commit_sym) begin
      need_space <= 1'b1;
    end
  end

  // Per-symbol status pulses; sym_code holds the last committed code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_valid <= 1'b0;
      sym_drop  <= 1'b0;
      sym_code  <= EMPTY_CODE;
    end else begin
      sym_valid <= commit;
      sym_drop  <= commit && pend;
      if (commit) sym_code <= commit_code;
    end
  end

  // Working buffer, pending flag and output frame registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '1;
      idx       <= '0;
      pend      <= 1'b0;
      sequences <= '1;
      frame_len <= '0;
      seq_valid <= 1'b0;
    end else if (pend && out_free) begin
      sequences <= work;
      frame_len <= idx;
      seq_valid <= 1'b1;
      work      <= '1;
      idx       <= '0;
      pend      <= 1'b0;
    end else begin
      if (seq_valid && seq_ready) seq_valid <= 1'b0;
      if (write) begin
        for (int i = 0; i < 16; i++) begin
          if (idx == 5'(i)) work[159-10*i -: 10] <= commit_code;
        end
        idx <= idx + 5'd1;
      end
      if (close_frame) pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_morse_key_capture.sv
// Directed bench for morse_key_capture with UNIT_CYCLES=4
// (dot = 4-cycle press, dash = 12-cycle press, letter gap 12, word gap 28).
module tb_morse_key_capture;

  localparam logic [9:0] C_E  = 10'h0FF;
  localparam logic [9:0] C_T  = 10'h1FF;
  localparam logic [9:0] C_A  = 10'h07F;
  localparam logic [9:0] C_SP = 10'h2FF;
  localparam logic [9:0] C_X  = 10'h3FF;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         key_in;
  logic         flush;
  logic         seq_ready;
  logic [159:0] sequences;
  logic         seq_valid;
  logic [4:0]   frame_len;
  logic         sym_valid;
  logic [9:0]   sym_code;
  logic         sym_drop;
  logic [1:0]   dbg_state;

  morse_key_capture #(
    .UNIT_CYCLES(4), .DASH_UNITS(2), .LETTER_UNITS(3), .WORD_UNITS(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .flush(flush),
    .seq_ready(seq_ready), .sequences(sequences), .seq_valid(seq_valid),
    .frame_len(frame_len), .sym_valid(sym_valid), .sym_code(sym_code),
    .sym_drop(sym_drop), .dbg_state(dbg_state)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  // Symbol monitor: every committed code and every drop pulse
  logic [9:0] sym_log[$];
  int drop_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sym_valid) sym_log.push_back(sym_code);
      if (sym_drop) drop_cnt++;
    end
  end

  function automatic logic [9:0] log_at(int i);
    if (i < sym_log.size()) return sym_log[i];
    return 10'h000;
  endfunction

  function automatic logic [159:0] fill(logic [9:0] c, int n);
    logic [159:0] r;
    r = '1;
    for (int i = 0; i < n; i++) r[159-10*i -: 10] = c;
    return r;
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic press(input int n);
    key_in = 1'b1;
    repeat (n) step();
    key_in = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seq"},   sequences,         {160{1'b1}});
    check({tag, "_sv"},    160'(seq_valid),   160'(0));
    check({tag, "_len"},   160'(frame_len),   160'(0));
    check({tag, "_symv"},  160'(sym_valid),   160'(0));
    check({tag, "_code"},  160'(sym_code),    160'(C_X));
    check({tag, "_drop"},  160'(sym_drop),    160'(0));
  endtask

  int base;
  int dbase;
  int bad;
  logic got;

  initial begin
    rst_n = 1'b0;
    key_in = 1'b0;
    flush = 1'b0;
    seq_ready = 1'b0;
    idle(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    idle(2);

    // E then flush: single-symbol frame
    base = sym_log.size();
    press(4);
    idle(20);
    check("e_count", 160'(sym_log.size() - base), 160'(1));
    check("e_code", 160'(log_at(base)), 160'(C_E));
    pulse_flush();
    check("e_sv_early", 160'(seq_valid), 160'(0));
    step();
    check("e_sv", 160'(seq_valid), 160'(1));
    check("e_frame", sequences, fill(C_E, 1));
    check("e_len", 160'(frame_len), 160'(1));
    seq_ready = 1'b1;
    step();
    seq_ready = 1'b0;
    check("e_sv_clr", 160'(seq_valid), 160'(0));
    idle(30);
    check("e_nospace", 160'(sym_log.size() - base), 160'(1));

    // A then word space; a second long idle adds no space
    base = sym_log.size();
    press(4);
    idle(4);
    press(12);
    idle(40);
    check("a_count", 160'(sym_log.size() - base), 160'(2));
    check("a_code", 160'(log_at(base)), 160'(C_A));
    check("sp_code", 160'(log_at(base + 1)), 160'(C_SP));
    idle(40);
    check("sp_once", 160'(sym_log.size() - base), 160'(2));
    pulse_flush();
    step();
    check("a_frame", sequences, {C_A, C_SP, {140{1'b1}}});
    check("a_len", 160'(frame_len), 160'(2));
    seq_ready = 1'b1;
    step();
    seq_ready = 1'b0;

    // Six dots overflow, then T decodes normally
    base = sym_log.size();
    for (int i = 0; i < 6; i++) begin
      press(4);
      idle(4);
    end
    idle(16);
    press(12);
    idle(16);
    check("ovf_count", 160'(sym_log.size() - base), 160'(2));
    check("ovf_code", 160'(log_at(base)), 160'(C_X));
    check("ovf_next", 160'(log_at(base + 1)), 160'(C_T));
    pulse_flush();
    step();
    check("ovf_frame", sequences, {C_X, C_T, {140{1'b1}}});
    seq_ready = 1'b1;
    step();

    // 16 T symbols with seq_ready=1: frame one cycle after 16th commit
    base = sym_log.size();
    for (int i = 0; i < 15; i++) begin
      press(12);
      idle(14);
    end
    press(12);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (sym_valid) got = 1'b1;
    end
    check("t16_commit_seen", 160'(got), 160'(1));
    check("t16_sv_before", 160'(seq_valid), 160'(0));
    step();
    check("t16_sv", 160'(seq_valid), 160'(1));
    check("t16_frame", sequences, fill(C_T, 16));
    check("t16_len", 160'(frame_len), 160'(16));
    idle(40);
    check("t16_count", 160'(sym_log.size() - base), 160'(16));
    bad = 0;
    for (int i = 0; i < 16; i++) if (log_at(base + i) !== C_T) bad++;
    check("t16_codes", 160'(bad), 160'(0));
    check("t16_sv_clr", 160'(seq_valid), 160'(0));

    // Back-pressure: two frames, then a dropped symbol
    seq_ready = 1'b0;
    base = sym_log.size();
    dbase = drop_cnt;
    for (int i = 0; i < 16; i++) begin
      press(12);
      idle(14);
    end
    for (int i = 0; i < 16; i++) begin
      press(4);
      idle(14);
    end
    check("bp_nodrop", 160'(drop_cnt - dbase), 160'(0));
    check("bp_sv", 160'(seq_valid), 160'(1));
    check("bp_frame1", sequences, fill(C_T, 16));
    press(12);
    idle(16);
    check("bp_drop", 160'(drop_cnt - dbase), 160'(1));
    check("bp_count", 160'(sym_log.size() - base), 160'(33));
    check("bp_hold", sequences, fill(C_T, 16));
    seq_ready = 1'b1;
    step();
    check("b2b_sv", 160'(seq_valid), 160'(1));
    check("b2b_frame2", sequences, fill(C_E, 16));
    check("b2b_len", 160'(frame_len), 160'(16));
    step();
    seq_ready = 1'b0;
    check("b2b_sv_clr", 160'(seq_valid), 160'(0));
    pulse_flush();
    idle(2);
    check("flush_empty", 160'(seq_valid), 160'(0));

    // Reset in the middle of a dash
    key_in = 1'b1;
    idle(8);
    rst_n = 1'b0;
    step();
    check_reset_outputs("mid");
    key_in = 1'b0;
    rst_n = 1'b1;
    idle(3);
    base = sym_log.size();
    press(4);
    idle(16);
    check("post_count", 160'(sym_log.size() - base), 160'(1));
    check("post_code", 160'(log_at(base)), 160'(C_E));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
